// File: rtl/uart_pkg.sv
// Shared types and oversampling constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;
   localparam int LAST_TICK  = OVERSAMPLE - 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; both flops reset to RST_VAL.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic sysclk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: start/data/parity/stop deserialiser with a
// valid/ack output register and per-word frame, parity and overrun flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            sysclk,
   input  logic            rst,
   input  logic            baudx16_ena,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ack,
   output logic            frame_err,
   output logic            parity_err,
   output logic            overrun_err
);

   localparam logic ODD = (PARITY_ODD != 0);
   localparam logic PEN = (PARITY_EN != 0);

   uart_rx_state_t  state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [3:0]      n_q, n_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic            ferr_q, ferr_d;
   logic            perr_q, perr_d;
   logic            frame_done;
   logic            rxs;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .sysclk (sysclk),
      .rst    (rst),
      .d      (rx),
      .q      (rxs)
   );

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      n_d        = n_q;
      shreg_d    = shreg_q;
      ferr_d     = ferr_q;
      perr_d     = perr_q;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (baudx16_ena) begin
               if (s_q == 5'(MID_TICK)) begin
                  // A start bit that is no longer low at its centre was noise.
                  if (!rxs) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                     ferr_d  = 1'b0;
                     perr_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (baudx16_ena) begin
               if (s_q == 5'(LAST_TICK)) begin
                  shreg_d = {rxs, shreg_q[DBIT-1:1]};
                  s_d     = '0;
                  if (n_q == 4'(DBIT-1))
                     state_d = PEN ? PARITY : STOP;
                  else
                     n_d = n_q + 4'd1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         PARITY: begin
            if (baudx16_ena) begin
               if (s_q == 5'(LAST_TICK)) begin
                  perr_d  = rxs ^ (^shreg_q) ^ ODD;
                  state_d = STOP;
                  s_d     = '0;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (baudx16_ena) begin
               if (s_q == 5'(LAST_TICK))
                  ferr_d = ~rxs;
               // Leaving at mid stop bit leaves half a bit to catch the next start edge.
               if (s_q == 5'(SB_TICK-1)) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
                  s_d        = '0;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ferr_d is used so a single stop bit's sample lands with its own word.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else if (frame_done) begin
         rx_data     <= shreg_q;
         frame_err   <= ferr_d;
         parity_err  <= perr_q;
         overrun_err <= rx_valid & ~rx_ack;
         rx_valid    <= 1'b1;
      end else if (rx_ack) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance plus an even-parity instance, fed by
// a MOD-27 baud strobe and a bit-serial line model.
module tb_uart_rx;

   localparam int BITT = 432;  // 16 ticks x 27 sysclk

   logic       sysclk = 1'b0;
   logic       rst = 1'b0;
   logic       tick;
   logic [4:0] bcnt;
   logic       rx = 1'b1, rx_p = 1'b1;
   logic       ack_man = 1'b0, ack_p = 1'b0, auto_en = 1'b0;
   logic       rx_ack;
   logic [7:0] rx_data, rx_data_p;
   logic       rx_valid, frame_err, parity_err, overrun_err;
   logic       rx_valid_p, frame_err_p, parity_err_p, overrun_err_p;
   int         total = 0, bad = 0;

   always #5 sysclk = ~sysclk;

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         bcnt <= '0;
         tick <= 1'b0;
      end else if (bcnt == 5'd26) begin
         bcnt <= '0;
         tick <= 1'b1;
      end else begin
         bcnt <= bcnt + 5'd1;
         tick <= 1'b0;
      end
   end

   // Auto-ack lands exactly on the completion cycle.
   assign rx_ack = ack_man | (auto_en & dut.frame_done);

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .sysclk(sysclk), .rst(rst), .baudx16_ena(tick), .rx(rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
   );

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .sysclk(sysclk), .rst(rst), .baudx16_ena(tick), .rx(rx_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ack(ack_p),
      .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun_err(overrun_err_p)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_bit(input logic b, input int clks, input bit p);
      if (p) rx_p = b;
      else   rx   = b;
      repeat (clks) @(negedge sysclk);
   endtask

   task automatic send(input logic [7:0] d, input bit p, input bit good_stop,
                       input bit use_par, input logic par);
      drive_bit(1'b0, BITT, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BITT, p);
      if (use_par) drive_bit(par, BITT, p);
      if (good_stop) drive_bit(1'b1, BITT, p);
      else begin
         drive_bit(1'b0, 260, p);
         drive_bit(1'b1, BITT, p);
      end
   endtask

   task automatic ack_main(input string tag);
      @(negedge sysclk) ack_man = 1'b1;
      @(negedge sysclk) ack_man = 1'b0;
      chk(tag, {31'd0, rx_valid}, 32'd0);
   endtask

   initial begin
      repeat (5) @(negedge sysclk);
      chk("rst_data",    {24'd0, rx_data}, 32'h0);
      chk("rst_valid",   {31'd0, rx_valid}, 32'd0);
      chk("rst_ferr",    {31'd0, frame_err}, 32'd0);
      chk("rst_perr",    {31'd0, parity_err}, 32'd0);
      chk("rst_ovr",     {31'd0, overrun_err}, 32'd0);
      rst = 1'b1;
      repeat (BITT) @(negedge sysclk);

      send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("a5_valid", {31'd0, rx_valid}, 32'd1);
      chk("a5_data",  {24'd0, rx_data}, 32'hA5);
      chk("a5_errs",  {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
      ack_main("a5_ack_clr");

      drive_bit(1'b0, 4*27, 1'b0);
      drive_bit(1'b1, 2*BITT, 1'b0);
      chk("glitch_valid", {31'd0, rx_valid}, 32'd0);

      send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("3c_data", {24'd0, rx_data}, 32'h3C);
      chk("3c_ferr", {31'd0, frame_err}, 32'd1);
      ack_main("3c_ack_clr");
      send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("01_valid", {31'd0, rx_valid}, 32'd1);
      chk("01_data",  {24'd0, rx_data}, 32'h01);
      chk("01_ferr",  {31'd0, frame_err}, 32'd0);
      ack_main("01_ack_clr");

      send(8'h37, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("p37_ok_valid", {31'd0, rx_valid_p}, 32'd1);
      chk("p37_ok_data",  {24'd0, rx_data_p}, 32'h37);
      chk("p37_ok_perr",  {31'd0, parity_err_p}, 32'd0);
      @(negedge sysclk) ack_p = 1'b1;
      @(negedge sysclk) ack_p = 1'b0;
      send(8'h37, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("p37_bad_perr", {31'd0, parity_err_p}, 32'd1);
      chk("p37_bad_ferr", {31'd0, frame_err_p}, 32'd0);
      chk("p37_bad_ovr",  {31'd0, overrun_err_p}, 32'd0);

      send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("b2b_55_data", {24'd0, rx_data}, 32'h55);
      chk("b2b_55_ovr",  {31'd0, overrun_err}, 32'd0);
      send(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("b2b_aa_data",  {24'd0, rx_data}, 32'hAA);
      chk("b2b_aa_ovr",   {31'd0, overrun_err}, 32'd1);
      chk("b2b_aa_valid", {31'd0, rx_valid}, 32'd1);
      ack_main("b2b_ack_clr");

      send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ack_55_valid", {31'd0, rx_valid}, 32'd1);
      auto_en = 1'b1;
      send(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
      auto_en = 1'b0;
      chk("ack_aa_data",  {24'd0, rx_data}, 32'hAA);
      chk("ack_aa_valid", {31'd0, rx_valid}, 32'd1);
      chk("ack_aa_ovr",   {31'd0, overrun_err}, 32'd0);

      // Abort 0xF0 part-way through its data bits.
      drive_bit(1'b0, BITT, 1'b0);
      drive_bit(1'b0, BITT, 1'b0);
      drive_bit(1'b0, BITT, 1'b0);
      drive_bit(1'b0, BITT/2, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst_data",  {24'd0, rx_data}, 32'h0);
      chk("arst_valid", {31'd0, rx_valid}, 32'd0);
      chk("arst_errs",  {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
      rx = 1'b1;
      repeat (3) @(negedge sysclk);
      rst = 1'b1;
      repeat (BITT) @(negedge sysclk);
      send(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("0f_valid", {31'd0, rx_valid}, 32'd1);
      chk("0f_data",  {24'd0, rx_data}, 32'h0F);
      chk("0f_errs",  {29'd0, frame_err, parity_err, overrun_err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
